// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the PC fetch controller
package pc_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP
    } pc_src_e;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux, +4 adder and redirect alignment check
module pc_next_sel
    import pc_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    pc_src_e src;

    always_comb begin
        pc_plus4 = pc + XLEN'(4);

        if (jump_en) begin
            src = SRC_JUMP;
        end else if (branch_taken) begin
            src = SRC_BRANCH;
        end else begin
            src = SRC_SEQ;
        end

        case (src)
            SRC_JUMP:   next_pc = jump_target;
            SRC_BRANCH: next_pc = branch_target;
            default:    next_pc = pc_plus4;
        endcase

        // Sequential flow from an aligned pc wraps cleanly, so only redirects are checked.
        misaligned = (src != SRC_SEQ) && !is_word_aligned(next_pc);
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// rtl/pc_fetch_controller.sv - PC register and fetch/issue sequencer for the RV32 core
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            instr_accept,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned_err
);

    pc_state_e       state;
    logic [XLEN-1:0] next_pc;
    logic            target_misaligned;
    logic            advance;

    pc_next_sel u_next_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (next_pc),
        .misaligned    (target_misaligned)
    );

    assign advance   = (state == ISSUE) && instr_accept && !stall;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req       <= 1'b0;
            instr_valid    <= 1'b0;
            misaligned_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state       <= ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (advance) begin
                        instr_valid <= 1'b0;
                        // A bad redirect freezes pc at the offending instruction for debug.
                        if (target_misaligned) begin
                            misaligned_err <= 1'b1;
                            state          <= HALT;
                        end else begin
                            pc       <= next_pc;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb/tb_pc_fetch_controller.sv - scoreboard bench for pc_fetch_controller
module tb_pc_fetch_controller;

    localparam logic [31:0] RST_PC_A = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;
    localparam int M_SEQ = 0, M_WAITSTALL = 1, M_RAND = 2, M_MIS = 3, M_HOLDC = 4, M_PRIO = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack, instr_accept, stall, branch_taken, jump_en;
    logic [31:0] branch_target, jump_target;

    logic        imem_req, instr_valid, misaligned_err;
    logic [31:0] imem_addr, pc, pc_plus4;
    logic        u2_imem_req, u2_instr_valid, u2_misaligned_err;
    logic [31:0] u2_imem_addr, u2_pc, u2_pc_plus4;

    pc_fetch_controller #(.RESET_PC(RST_PC_A)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .instr_accept(instr_accept), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump_en(jump_en),
        .jump_target(jump_target), .pc(pc), .pc_plus4(pc_plus4), .misaligned_err(misaligned_err)
    );

    pc_fetch_controller #(.RESET_PC(RST_PC_B)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(u2_imem_req), .imem_addr(u2_imem_addr), .imem_ack(imem_ack),
        .instr_valid(u2_instr_valid), .instr_accept(instr_accept), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump_en(jump_en),
        .jump_target(jump_target), .pc(u2_pc), .pc_plus4(u2_pc_plus4), .misaligned_err(u2_misaligned_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc, wrap_exp, held_addr;
    bit          err_model, halt_pending, exp_halt, drv_en, seq_prev_valid;
    int          mode, cyc, fetch_cnt, last_fetch_cyc, wait_cnt, issue_cnt, req_run, valid_run;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_q.push_back(RST_PC_A);
        model_pc       = RST_PC_A;
        wrap_exp       = RST_PC_B;
        err_model      = 0;
        halt_pending   = 0;
        exp_halt       = 0;
        seq_prev_valid = 0;
        fetch_cnt      = 0;
        req_run        = 0;
        valid_run      = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_fetches(input int n, input int budget, input string what);
        int k = 0;
        while (fetch_cnt < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (fetch_cnt < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d fetches expected %0d", what, fetch_cnt, n);
        end
    endtask

    task automatic drive_idle();
        imem_ack      = 1'b0;
        instr_accept  = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        jump_en       = 1'b0;
        branch_target = '0;
        jump_target   = '0;
    endtask

    // Driver: memory responder, decode agent, and reference model of the PC sequence.
    initial begin
        logic [31:0] t, nxt;
        int          ack_delay;
        drive_idle();
        wait_cnt  = 0;
        issue_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            drive_idle();
            if (!rst_n || !drv_en) begin
                wait_cnt  = 0;
                issue_cnt = 0;
            end else begin
                if (imem_req) begin
                    ack_delay = 0;
                    if (mode == M_WAITSTALL && imem_addr == 32'h4) ack_delay = 3;
                    else if (mode == M_RAND || mode == M_MIS) ack_delay = $urandom_range(0, 2);
                    else if (mode == M_HOLDC && imem_addr == 32'hC) ack_delay = 1000;
                    imem_ack = (wait_cnt >= ack_delay);
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (mode == M_RAND || mode == M_MIS) imem_ack = 1'($urandom_range(0, 1));
                end
                if (instr_valid) issue_cnt++;
                else issue_cnt = 0;

                if (mode == M_RAND) begin
                    instr_accept = ($urandom_range(0, 3) != 0);
                    stall        = ($urandom_range(0, 3) == 0);
                    jump_en      = ($urandom_range(0, 7) == 0);
                    branch_taken = ($urandom_range(0, 5) == 0);
                    t = $urandom(); t[1:0] = 2'b00; jump_target = t;
                    t = $urandom(); t[1:0] = 2'b00; branch_target = t;
                end else if (mode == M_MIS) begin
                    instr_accept  = 1'b1;
                    jump_en       = 1'b1;
                    jump_target   = 32'h102;
                    branch_taken  = 1'b1;
                    branch_target = 32'h40;
                end else begin
                    instr_accept = 1'b1;
                    stall = (mode == M_WAITSTALL) && instr_valid && model_pc == 32'h4 && issue_cnt <= 2;
                    if (mode == M_PRIO && model_pc == 32'h8) begin
                        jump_en = 1'b1; jump_target = 32'h100;
                        branch_taken = 1'b1; branch_target = 32'h40;
                    end else if (mode == M_PRIO && model_pc == 32'h100) begin
                        branch_taken = 1'b1; branch_target = 32'h40;
                    end
                end

                if (instr_valid && instr_accept && !stall) begin
                    nxt = jump_en ? jump_target : (branch_taken ? branch_target : model_pc + 32'd4);
                    if ((jump_en || branch_taken) && nxt[1:0] != 2'b00) begin
                        halt_pending = 1;
                        exp_halt     = 1;
                    end else begin
                        model_pc = nxt;
                        exp_q.push_back(nxt);
                    end
                end
            end
        end
    end

    // Monitor: pops expected fetch addresses and checks protocol invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (err_model) begin
                    check("halt_imem_req", {31'b0, imem_req}, 32'd0);
                    check("halt_instr_valid", {31'b0, instr_valid}, 32'd0);
                    check("halt_pc_frozen", pc, model_pc);
                end
                check("misaligned_err", {31'b0, misaligned_err}, {31'b0, err_model});
                if (halt_pending) begin
                    err_model    = 1;
                    halt_pending = 0;
                end
                if (imem_req && instr_valid) check("req_valid_exclusive", 32'd1, 32'd0);
                if (imem_req) begin
                    if (req_run > 0) check("imem_addr_stable", imem_addr, held_addr);
                    held_addr = imem_addr;
                    req_run++;
                end
                if (imem_req && imem_ack) begin
                    check("pc_plus4", pc_plus4, pc + 32'd4);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
                    end else begin
                        check("fetch_addr", imem_addr, exp_q.pop_front());
                    end
                    if (mode == M_WAITSTALL && imem_addr == 32'h4) check("fetch_wait_len", req_run, 4);
                    if (mode == M_SEQ) begin
                        if (seq_prev_valid) check("fetch_period", cyc - last_fetch_cyc, 2);
                        seq_prev_valid = 1;
                        last_fetch_cyc = cyc;
                        check("wrap_addr", u2_imem_addr, wrap_exp);
                        check("wrap_req", {31'b0, u2_imem_req}, 32'd1);
                        check("wrap_err", {31'b0, u2_misaligned_err}, 32'd0);
                        wrap_exp = wrap_exp + 32'd4;
                    end
                    fetch_cnt++;
                end
                if (!imem_req || imem_ack) req_run = 0;
                if (instr_valid) begin
                    valid_run++;
                    if (instr_accept && !stall) begin
                        if (mode == M_WAITSTALL && pc == 32'h4) check("issue_len", valid_run, 3);
                        valid_run = 0;
                    end
                end else begin
                    valid_run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        drv_en = 0;
        mode   = M_SEQ;
        clear_model();
        #2 rst_n = 1'b0;
        #1;
        check("rst_pc", pc, RST_PC_A);
        check("rst_pc_plus4", pc_plus4, RST_PC_A + 32'd4);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misaligned_err", {31'b0, misaligned_err}, 32'd0);
        check("rst_wrap_pc", u2_pc, RST_PC_B);
        check("rst_wrap_pc_plus4", u2_pc_plus4, 32'h0);
        check("rst_wrap_valid", {31'b0, u2_instr_valid}, 32'd0);

        drv_en = 1;
        apply_reset();
        mode = M_SEQ;
        wait_fetches(5, 40, "sequential");

        apply_reset();
        mode = M_WAITSTALL;
        wait_fetches(4, 60, "wait_stall");

        apply_reset();
        mode = M_PRIO;
        wait_fetches(6, 60, "redirect_priority");

        apply_reset();
        mode = M_RAND;
        wait_fetches(150, 3000, "random");

        mode = M_MIS;
        k = 0;
        while (!err_model && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("halt_reached", {31'b0, err_model}, 32'd1);
        repeat (6) @(negedge clk);
        #1;

        mode = M_HOLDC;
        apply_reset();
        k = 0;
        while (!(imem_req && imem_addr == 32'hC) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("hold_at_c", imem_addr, 32'hC);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_imem_req", {31'b0, imem_req}, 32'd0);
        check("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_pc", pc, RST_PC_A);
        drv_en = 0;
        mode   = M_SEQ;
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        #1;
        check("late_ack_idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        #1;
        check("late_ack_ignored", {31'b0, instr_valid}, 32'd0);
        check("first_fetch_req", {31'b0, imem_req}, 32'd1);
        check("first_fetch_addr", imem_addr, RST_PC_A);
        drv_en = 1;
        wait_fetches(3, 30, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
